// File: rtl/fetch_queue_pkg.sv
// Shared constants and the per-cycle operation encoding for the fetch queue.
// WORD_ZERO and PC_INCR are the common constants; fetch_queue does not redefine them locally.
package fetch_queue_pkg;

  localparam logic [63:0] WORD_ZERO = 64'h0;
  localparam int unsigned PC_INCR   = 4;

  typedef enum logic [2:0] {
    FQ_OP_IDLE  = 3'd0,
    FQ_OP_PUSH  = 3'd1,
    FQ_OP_POP   = 3'd2,
    FQ_OP_BOTH  = 3'd3,
    FQ_OP_FLUSH = 3'd4
  } fq_op_e;

  function automatic fq_op_e fq_decode(input logic flush, input logic push_acc,
                                       input logic pop_acc);
    if (flush)                    return FQ_OP_FLUSH;
    else if (push_acc && pop_acc) return FQ_OP_BOTH;
    else if (push_acc)            return FQ_OP_PUSH;
    else if (pop_acc)             return FQ_OP_POP;
    else                          return FQ_OP_IDLE;
  endfunction

endpackage

// File: rtl/fetch_queue_mem.sv
// Fetch queue storage (module fq_mem): DEPTH x DATA_W, one synchronous write port,
// one asynchronous read port, no reset.
module fq_mem #(
  parameter int DEPTH  = 4,
  parameter int DATA_W = 64
) (
  input  logic                     clk,
  input  logic                     we,
  input  logic [$clog2(DEPTH)-1:0] waddr,
  input  logic [DATA_W-1:0]        wdata,
  input  logic [$clog2(DEPTH)-1:0] raddr,
  output logic [DATA_W-1:0]        rdata
);

  logic [DATA_W-1:0] mem [DEPTH];

  always_ff @(posedge clk) begin
    if (we) mem[waddr] <= wdata;
  end

  assign rdata = mem[raddr];

endmodule

// File: rtl/fetch_queue.sv
// First-word-fall-through fetch queue holding {pc+4, instr} pairs between fetch and decode.
// Optional event trace is enabled by defining FETCH_QUEUE_TRACE_EN.
module fetch_queue
  import fetch_queue_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [WIDTH-1:0]         pc_in,
  input  logic [WIDTH-1:0]         instr_in,
  input  logic                     push,
  input  logic                     pop,
  input  logic                     flush,
  output logic                     pc_write,
  output logic [WIDTH-1:0]         instr_out,
  output logic [WIDTH-1:0]         pc4_out,
  output logic                     valid_out,
  output logic [$clog2(DEPTH):0]   count
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);
  localparam logic [WIDTH-1:0] ZERO_W = WORD_ZERO[WIDTH-1:0];

  logic [AW-1:0]      wr_ptr;
  logic [AW-1:0]      rd_ptr;
  logic [CW-1:0]      count_q;
  logic               full;
  logic               empty;
  logic               push_acc;
  logic               pop_acc;
  logic [2*WIDTH-1:0] wdata;
  logic [2*WIDTH-1:0] rdata;
  fq_op_e             op;

  assign full  = (count_q == FULL_CNT);
  assign empty = (count_q == '0);

  // A pop in the same cycle frees a slot, so a full queue can still take a push.
  assign pc_write = ~flush & (~full | (pop & ~empty));
  assign push_acc = push & pc_write;
  assign pop_acc  = pop & ~empty & ~flush;
  assign op       = fq_decode(flush, push_acc, pop_acc);

  assign wdata = {pc_in + WIDTH'(PC_INCR), instr_in};

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr  <= '0;
      rd_ptr  <= '0;
      count_q <= '0;
    end else begin
      case (op)
        FQ_OP_FLUSH: begin
          wr_ptr  <= '0;
          rd_ptr  <= '0;
          count_q <= '0;
        end
        FQ_OP_PUSH: begin
          wr_ptr  <= wr_ptr + 1'b1;
          count_q <= count_q + 1'b1;
        end
        FQ_OP_POP: begin
          rd_ptr  <= rd_ptr + 1'b1;
          count_q <= count_q - 1'b1;
        end
        FQ_OP_BOTH: begin
          wr_ptr <= wr_ptr + 1'b1;
          rd_ptr <= rd_ptr + 1'b1;
        end
        default: ;
      endcase
    end
  end

  fq_mem #(
    .DEPTH  (DEPTH),
    .DATA_W (2*WIDTH)
  ) u_mem (
    .clk   (clk),
    .we    (push_acc),
    .waddr (wr_ptr),
    .wdata (wdata),
    .raddr (rd_ptr),
    .rdata (rdata)
  );

  // Storage is never cleared, so the head is gated to avoid exposing stale words.
  assign valid_out = ~empty;
  assign instr_out = valid_out ? rdata[WIDTH-1:0]       : ZERO_W;
  assign pc4_out   = valid_out ? rdata[2*WIDTH-1:WIDTH] : ZERO_W;
  assign count     = count_q;

`ifdef FETCH_QUEUE_TRACE_EN
  always @(posedge clk or posedge rst) begin
    if (rst) begin
      $display("@%0t: FQ::RESET", $time);
    end else begin
      if (flush)    $display("@%0t: FQ flush", $time);
      if (push_acc) $display("@%0t: FQ push pc=%h", $time, pc_in);
      if (pop_acc)  $display("@%0t: FQ pop pc4=%h", $time, pc4_out);
    end
  end
`endif

endmodule

// File: tb/tb_fetch_queue.sv
// Scoreboard bench for fetch_queue: a queue-based reference model predicts acceptance
// and contents; a negedge monitor checks every entry decode consumes.
module tb_fetch_queue;

  localparam int DEPTH = 4;
  localparam int WIDTH = 32;

  logic             clk;
  logic             rst;
  logic [WIDTH-1:0] pc_in;
  logic [WIDTH-1:0] instr_in;
  logic             push;
  logic             pop;
  logic             flush;
  logic             pc_write;
  logic [WIDTH-1:0] instr_out;
  logic [WIDTH-1:0] pc4_out;
  logic             valid_out;
  logic [$clog2(DEPTH):0] count;

  int tests;
  int fails;

  // Reference model: the queue itself, each entry {pc+4, instr}.
  logic [2*WIDTH-1:0] exp_q [$];

  fetch_queue #(.DEPTH(DEPTH), .WIDTH(WIDTH)) dut (
    .clk       (clk),
    .rst       (rst),
    .pc_in     (pc_in),
    .instr_in  (instr_in),
    .push      (push),
    .pop       (pop),
    .flush     (flush),
    .pc_write  (pc_write),
    .instr_out (instr_out),
    .pc4_out   (pc4_out),
    .valid_out (valid_out),
    .count     (count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // Monitor: every accepted pop must hand out the oldest expected entry.
  always @(negedge clk) begin
    if (!rst && pop && !flush && valid_out) begin
      if (exp_q.size() == 0) begin
        tests++;
        fails++;
        $display("FAIL pop_unexpected: got pc4=%h expected no entry", pc4_out);
      end else begin
        logic [2*WIDTH-1:0] e;
        e = exp_q.pop_front();
        chk("pop_pc4", 64'(pc4_out), 64'(e[2*WIDTH-1:WIDTH]));
        chk("pop_instr", 64'(instr_out), 64'(e[WIDTH-1:0]));
      end
    end
  end

  task automatic check_state();
    int n;
    n = exp_q.size();
    chk("count", 64'(count), 64'(n));
    chk("valid_out", 64'(valid_out), 64'(n > 0));
    if (n == 0) begin
      chk("instr_zero", 64'(instr_out), 64'h0);
      chk("pc4_zero", 64'(pc4_out), 64'h0);
    end
  endtask

  // Called shortly after a rising edge; returns shortly after the next one.
  task automatic cycle(input logic p, input logic po, input logic f,
                       input logic [WIDTH-1:0] pc, input logic [WIDTH-1:0] ins);
    logic exp_pw;
    logic [WIDTH-1:0] pc4;
    check_state();
    push = p; pop = po; flush = f; pc_in = pc; instr_in = ins;
    #1;
    exp_pw = !f && ((exp_q.size() < DEPTH) || (po && exp_q.size() > 0));
    chk("pc_write", 64'(pc_write), 64'(exp_pw));
    pc4 = pc + 32'd4;
    if (f) exp_q.delete();
    else if (p && exp_pw) exp_q.push_back({pc4, ins});
    @(posedge clk);
    #1;
    push = 1'b0; pop = 1'b0; flush = 1'b0;
  endtask

  initial begin
    tests = 0; fails = 0;
    rst = 1'b1; push = 1'b0; pop = 1'b0; flush = 1'b0;
    pc_in = '0; instr_in = '0;

    #100;
    chk("rst_count", 64'(count), 64'h0);
    chk("rst_valid", 64'(valid_out), 64'h0);
    chk("rst_pc_write", 64'(pc_write), 64'h1);
    chk("rst_instr", 64'(instr_out), 64'h0);
    chk("rst_pc4", 64'(pc4_out), 64'h0);
    #350;
    rst = 1'b0;
    @(posedge clk); #1;

    // Fill to DEPTH, then a fifth push that must be refused.
    for (int i = 0; i < 4; i++) cycle(1'b1, 1'b0, 1'b0, 32'(i*4), 32'hA0 + 32'(i));
    chk("fill_count", 64'(count), 64'd4);
    chk("fill_head_pc4", 64'(pc4_out), 64'd4);
    cycle(1'b1, 1'b0, 1'b0, 32'd16, 32'hA4);
    chk("fifth_dropped", 64'(count), 64'd4);

    // Push and pop together while full.
    cycle(1'b1, 1'b1, 1'b0, 32'd16, 32'hA4);
    chk("full_both_count", 64'(count), 64'd4);
    chk("full_both_head", 64'(pc4_out), 64'd8);

    // Drain, then ten push/pop pairs to wrap the pointers.
    for (int i = 0; i < 4; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0);
    cycle(1'b1, 1'b0, 1'b0, 32'h100, 32'hB0);
    for (int i = 0; i < 10; i++) cycle(1'b1, 1'b1, 1'b0, 32'h104 + 32'(i*4), 32'hB1 + 32'(i));
    chk("wrap_count", 64'(count), 64'd1);

    // Bring occupancy to 3, then flush with push and pop in the same cycle.
    cycle(1'b1, 1'b0, 1'b0, 32'h200, 32'hC0);
    cycle(1'b1, 1'b0, 1'b0, 32'h204, 32'hC1);
    chk("pre_flush_count", 64'(count), 64'd3);
    cycle(1'b1, 1'b1, 1'b1, 32'h300, 32'hDEAD);
    chk("flush_count", 64'(count), 64'd0);
    chk("flush_valid", 64'(valid_out), 64'd0);
    chk("flush_instr", 64'(instr_out), 64'd0);

    // Pop on empty, then the PC wrap-around case.
    cycle(1'b0, 1'b1, 1'b0, '0, '0);
    chk("empty_pop_count", 64'(count), 64'd0);
    cycle(1'b1, 1'b0, 1'b0, 32'hFFFF_FFFC, 32'hE0);
    chk("pc_wrap_pc4", 64'(pc4_out), 64'd0);
    chk("pc_wrap_valid", 64'(valid_out), 64'd1);
    cycle(1'b0, 1'b1, 1'b0, '0, '0);

    // Randomized traffic.
    for (int i = 0; i < 400; i++) begin
      logic p, po, f;
      p  = ($urandom_range(0, 99) < 60);
      po = ($urandom_range(0, 99) < 45);
      f  = ($urandom_range(0, 99) < 4);
      cycle(p, po, f, $urandom() & 32'hFFFF_FFFC, $urandom());
    end

    // Asynchronous reset mid-operation.
    cycle(1'b1, 1'b0, 1'b0, 32'h400, 32'hF0);
    cycle(1'b1, 1'b0, 1'b0, 32'h404, 32'hF1);
    #2;
    rst = 1'b1;
    #1;
    chk("midrst_count", 64'(count), 64'd0);
    chk("midrst_valid", 64'(valid_out), 64'd0);
    chk("midrst_pc4", 64'(pc4_out), 64'd0);
    chk("midrst_pc_write", 64'(pc_write), 64'd1);
    exp_q.delete();
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk); #1;
    cycle(1'b1, 1'b0, 1'b0, 32'h500, 32'h77);
    chk("post_rst_push", 64'(count), 64'd1);

    // Bounded drain.
    for (int i = 0; i < 2*DEPTH && exp_q.size() > 0; i++) cycle(1'b0, 1'b1, 1'b0, '0, '0);
    chk("drain_left", 64'(exp_q.size()), 64'd0);
    check_state();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
